instr_mem_loader: RTL and testbench

Write-side counterpart of the instruction memory's unaligned word-fetch port. It accepts a byte stream over a valid/ready handshake starting at an arbitrary byte address. It packs the bytes into big-endian 32-bit words and issues one masked word write per touched word into the word-organized instruction RAM. It sits between the program-load source (bench or boot path) and the instruction RAM write port, and lets code be placed without a `$readmemb` preload.

---
 rtl/instr_mem_loader.sv | 193 +++++++++++++++++++
 tb/tb_instr_mem_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// instr_mem_loader
// Packs a byte stream, starting at an arbitrary byte address, into big-endian
// 32-bit words and issues one masked word write per touched word into the
// word-organized instruction RAM.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   begin a load (only honoured in IDLE)
//   base_addr  in   byte address of the first byte, sampled with start
//   in_valid   in   byte available
//   in_byte    in   byte data
//   in_last    in   marks the final byte of the stream
//   in_ready   out  loader accepts a byte this cycle (state only)
//   wr_en      out  one-cycle RAM write strobe
//   wr_addr    out  word index of the write
//   wr_data    out  assembled big-endian word
//   wr_mask    out  byte enables, bit 3 covers bits 31:24
//   busy       out  high outside IDLE
//   done       out  one-cycle pulse at the end of a load
//   err        out  sticky: a write targeted a word index >= DEPTH
module instr_mem_loader #(
  parameter int WORD  = 32,
  parameter int BYTE  = 8,
  parameter int DEPTH = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [WORD-1:0] base_addr,
  input  logic            in_valid,
  input  logic [BYTE-1:0] in_byte,
  input  logic            in_last,
  output logic            in_ready,
  output logic            wr_en,
  output logic [WORD-1:0] wr_addr,
  output logic [WORD-1:0] wr_data,
  output logic [3:0]      wr_mask,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam logic [WORD-1:0] DEPTH_W = WORD'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_r;
  state_t          next_s;
  logic [WORD-1:0] cur_addr_r;
  logic [WORD-1:0] asm_data_r;
  logic [3:0]      asm_mask_r;
  logic            last_seen_r;
  logic            wr_en_r;
  logic [WORD-1:0] wr_addr_r;
  logic [WORD-1:0] wr_data_r;
  logic [3:0]      wr_mask_r;
  logic            err_r;
  logic            in_ready_s;
  logic            busy_s;
  logic            done_s;
  logic [1:0]      lane_s;
  logic            word_end_s;
  logic [WORD-1:0] word_idx_s;

  // Big-endian lane placement: offset 0 lands in the most significant byte.
  function automatic logic [WORD-1:0] lane_data(input logic [BYTE-1:0] b, input logic [1:0] k);
    lane_data = {b, {(WORD-BYTE){1'b0}}} >> (BYTE * int'(k));
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] k);
    lane_mask = 4'b1000 >> k;
  endfunction

  assign lane_s     = cur_addr_r[1:0];
  assign word_end_s = (lane_s == 2'd3) || in_last;
  // Word of the byte being accepted, i.e. (cur_addr+1-1)>>2 once it is written.
  assign word_idx_s = cur_addr_r >> 2;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) next_s = S_FILL;
        else       next_s = S_IDLE;
      end
      S_FILL: begin
        if (in_valid && word_end_s) next_s = S_WRITE;
        else                        next_s = S_FILL;
      end
      S_WRITE: begin
        if (last_seen_r) next_s = S_DONE;
        else             next_s = S_FILL;
      end
      S_DONE:  next_s = S_IDLE;
      default: next_s = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    in_ready_s = 1'b0;
    busy_s     = 1'b1;
    done_s     = 1'b0;
    case (state_r)
      S_IDLE:  busy_s     = 1'b0;
      S_FILL:  in_ready_s = 1'b1;
      S_WRITE: in_ready_s = 1'b0;
      S_DONE:  done_s     = 1'b1;
      default: busy_s     = 1'b0;
    endcase
  end

  // Datapath: address counter, word assembly and the registered write port.
  // The write port is loaded on the edge that enters WRITE, so the strobe is
  // visible exactly during the WRITE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr_r  <= {WORD{1'b0}};
      asm_data_r  <= {WORD{1'b0}};
      asm_mask_r  <= 4'b0000;
      last_seen_r <= 1'b0;
      wr_en_r     <= 1'b0;
      wr_addr_r   <= {WORD{1'b0}};
      wr_data_r   <= {WORD{1'b0}};
      wr_mask_r   <= 4'b0000;
      err_r       <= 1'b0;
    end else begin
      wr_en_r   <= 1'b0;
      wr_addr_r <= {WORD{1'b0}};
      wr_data_r <= {WORD{1'b0}};
      wr_mask_r <= 4'b0000;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            cur_addr_r <= base_addr;
            asm_data_r <= {WORD{1'b0}};
            asm_mask_r <= 4'b0000;
            err_r      <= 1'b0;
          end
        end
        S_FILL: begin
          if (in_valid) begin
            cur_addr_r <= cur_addr_r + {{(WORD-1){1'b0}}, 1'b1};
            if (word_end_s) begin
              wr_en_r     <= (word_idx_s < DEPTH_W);
              wr_addr_r   <= word_idx_s;
              wr_data_r   <= asm_data_r | lane_data(in_byte, lane_s);
              wr_mask_r   <= asm_mask_r | lane_mask(lane_s);
              asm_data_r  <= {WORD{1'b0}};
              asm_mask_r  <= 4'b0000;
              last_seen_r <= in_last;
            end else begin
              asm_data_r <= asm_data_r | lane_data(in_byte, lane_s);
              asm_mask_r <= asm_mask_r | lane_mask(lane_s);
            end
          end
        end
        S_WRITE: begin
          // Out-of-range word: strobe was suppressed, flag it and keep draining.
          if (wr_addr_r >= DEPTH_W) err_r <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready = in_ready_s;
  assign busy     = busy_s;
  assign done     = done_s;
  assign wr_en    = wr_en_r;
  assign wr_addr  = wr_addr_r;
  assign wr_data  = wr_data_r;
  assign wr_mask  = wr_mask_r;
  assign err      = err_r;

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_last;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  instr_mem_loader #(.WORD(32), .BYTE(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_byte(in_byte), .in_last(in_last),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mask(wr_mask), .busy(busy),
    .done(done), .err(err)
  );

  typedef struct {
    logic [31:0] idx;
    logic [31:0] data;
    logic [3:0]  mask;
  } wexp_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  int          wr_cnt   = 0;
  int          done_cnt = 0;
  logic [7:0]  bytes_q[$];
  wexp_t       exp_q[$];

  // One clock, then sample outputs well after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (wr_en === 1'b1) wr_cnt++;
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: walk the byte addresses, group bytes by word index and place
  // each one big-endian within its word.
  task automatic build_model(input logic [31:0] base);
    wexp_t       t;
    logic [31:0] a;
    int          k;
    exp_q.delete();
    for (int i = 0; i < bytes_q.size(); i++) begin
      a = base + 32'(i);
      k = int'(a % 32'd4);
      if (i == 0 || k == 0) begin
        t.idx  = a / 32'd4;
        t.data = 32'h0;
        t.mask = 4'h0;
        exp_q.push_back(t);
      end
      t = exp_q.pop_back();
      t.data = t.data | (32'(bytes_q[i]) << (8 * (3 - k)));
      t.mask = t.mask | 4'(1 << (3 - k));
      exp_q.push_back(t);
    end
  endtask

  task automatic load(input logic [31:0] base, input int gap, input bit fixed_gap, input bit mid_start);
    int          n;
    int          w;
    int          cyc;
    int          i;
    int          ng;
    int          en_count;
    int          wr_before;
    int          done_before;
    bit          acc;
    logic        exp_err;
    logic [31:0] a;
    n = bytes_q.size();
    build_model(base);
    en_count = 0;
    exp_err  = 1'b0;
    foreach (exp_q[j]) begin
      if (exp_q[j].idx < 32'(DEPTH)) en_count++;
      else exp_err = 1'b1;
    end
    wr_before   = wr_cnt;
    done_before = done_cnt;

    start = 1'b1; base_addr = base;
    step();
    start = 1'b0; base_addr = $urandom;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("err_cleared_by_start", 32'(err), 32'd0);

    i = 0; w = 0; cyc = 0;
    while (i < n && cyc < 200) begin
      ng = fixed_gap ? gap : ((gap > 0) ? int'($urandom_range(0, gap)) : 0);
      for (int g = 0; g < ng; g++) begin
        in_valid = 1'b0; in_byte = 8'($urandom); in_last = 1'($urandom);
        step(); cyc++;
      end
      if (mid_start && i == 1) begin
        start = 1'b1; base_addr = 32'h40;
      end
      in_valid = 1'b1; in_byte = bytes_q[i]; in_last = (i == n - 1);
      acc = in_ready;
      step(); cyc++;
      start = 1'b0;
      if (acc) begin
        a = base + 32'(i);
        if (i == n - 1 || a % 32'd4 == 32'd3) begin
          chk("in_ready_in_write", 32'(in_ready), 32'd0);
          chk("wr_en", 32'(wr_en), 32'(exp_q[w].idx < 32'(DEPTH)));
          chk("wr_addr", wr_addr, exp_q[w].idx);
          chk("wr_data", wr_data, exp_q[w].data);
          chk("wr_mask", 32'(wr_mask), 32'(exp_q[w].mask));
          w++;
        end
        i++;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("stream_timeout", 32'(cyc < 200), 32'd1);

    step();
    chk("done_pulse", 32'(done), 32'd1);
    chk("err_at_done", 32'(err), 32'(exp_err));
    step();
    chk("done_low_after", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("wr_count", 32'(wr_cnt - wr_before), 32'(en_count));
    chk("done_count", 32'(done_cnt - done_before), 32'd1);
  endtask

  initial begin
    int wb;
    rst = 1'b1; start = 1'b0; base_addr = 32'h0;
    in_valid = 1'b0; in_byte = 8'h00; in_last = 1'b0;
    step(); step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", wr_addr, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_wr_mask", 32'(wr_mask), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    step();

    // Aligned load, five bytes.
    bytes_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    load(32'h0, 0, 1'b0, 1'b0);
    // Unaligned start.
    bytes_q = '{8'hAA, 8'hBB, 8'hCC};
    load(32'h6, 0, 1'b0, 1'b0);
    // Source gaps of three cycles between bytes.
    bytes_q = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    load(32'h0, 3, 1'b1, 1'b0);
    // Overflow past DEPTH.
    bytes_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    load(32'hE, 0, 1'b0, 1'b0);
    // start during FILL is ignored (also shows err cleared by this start).
    bytes_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    load(32'h1, 0, 1'b0, 1'b1);

    // Reset in the middle of a load.
    wb = wr_cnt;
    start = 1'b1; base_addr = 32'h0;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_last = 1'b0; in_byte = 8'h5A;
    step();
    in_byte = 8'hA5;
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
    chk("mid_rst_wr_addr", wr_addr, 32'd0);
    chk("mid_rst_wr_data", wr_data, 32'd0);
    chk("mid_rst_wr_mask", 32'(wr_mask), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    step(); step();
    chk("mid_rst_no_write", 32'(wr_cnt - wb), 32'd0);
    bytes_q = '{8'h10, 8'h20, 8'h30};
    load(32'h3, 0, 1'b0, 1'b0);

    // Address wrap at the top of the address space.
    bytes_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    load(32'hFFFF_FFFE, 0, 1'b0, 1'b0);

    // Randomized loads.
    for (int r = 0; r < 10; r++) begin
      int nb;
      nb = int'($urandom_range(1, 9));
      bytes_q.delete();
      for (int b = 0; b < nb; b++) bytes_q.push_back(8'($urandom));
      load(32'($urandom_range(0, 31)), int'($urandom_range(0, 3)), 1'b0, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
